// File: rtl/hawk_axiwr_arb.sv
// hawk_axiwr_arb
//   Round-robin arbiter that shares the single hawk AXI write master among
//   NREQ write requesters. One write is outstanding at a time. The grant is
//   held from arbitration through the AW/W handshakes until the B response
//   returns, and the B response is routed back to the granted requester only.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_addr/data/strb        per-requester payload, requester i at slice i
//   req_awvalid/req_wvalid    per-requester address/data valid
//   req_awready/req_wready    one-hot accept pulses back to the requesters
//   req_bvalid/req_bresp      one-hot write response and its code
//   m_*                       AXI write master side (AW, W, B channels)
//   gnt_idx                   current or most recent granted requester
//   busy                      high whenever a write is being arbitrated/served
//   err_cnt                   saturating count of non-OKAY responses
module hawk_axiwr_arb #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ*64-1:0]    req_addr,
    input  logic [NREQ*512-1:0]   req_data,
    input  logic [NREQ*64-1:0]    req_strb,
    input  logic [NREQ-1:0]       req_awvalid,
    input  logic [NREQ-1:0]       req_wvalid,
    output logic [NREQ-1:0]       req_awready,
    output logic [NREQ-1:0]       req_wready,
    output logic [NREQ-1:0]       req_bvalid,
    output logic [1:0]            req_bresp,
    output logic [63:0]           m_addr,
    output logic [511:0]          m_data,
    output logic [63:0]           m_strb,
    output logic                  m_awvalid,
    output logic                  m_wvalid,
    input  logic                  m_awready,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic [IDW-1:0]        gnt_idx,
    output logic                  busy,
    output logic [15:0]           err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_WAITB = 2'd2;
    localparam int         SW       = IDW + 1;

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic            aw_done;
    logic            w_done;
    logic [SW-1:0]   scan;
    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] gnt_oh;
    logic            in_xfer;
    logic            b_route;
    logic            aw_hs;
    logic            w_hs;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scan from rr_ptr upward with wrap; rr_ptr < NREQ so a single
    // conditional subtract is enough to fold the index back into range.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
            if (!pick_vld && |(req_awvalid & (NREQ'(1) << scan))) begin
                pick_vld = 1'b1;
                pick_idx = scan[IDW-1:0];
            end
        end
    end

    assign gnt_oh  = NREQ'(1) << gnt_idx;
    assign in_xfer = (state == ST_XFER);
    assign b_route = (state == ST_WAITB) && m_bvalid;
    assign busy    = (state != ST_IDLE);

    // Payload is only presented while transferring so the master sees
    // zeros whenever no grant is active.
    always_comb begin
        m_addr = '0;
        m_data = '0;
        m_strb = '0;
        if (in_xfer) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_idx == IDW'(i)) begin
                    m_addr = req_addr[i*64 +: 64];
                    m_data = req_data[i*512 +: 512];
                    m_strb = req_strb[i*64 +: 64];
                end
            end
        end
    end

    assign m_awvalid   = in_xfer && |(req_awvalid & gnt_oh) && !aw_done;
    assign m_wvalid    = in_xfer && |(req_wvalid & gnt_oh) && !w_done;
    assign aw_hs       = m_awvalid && m_awready;
    assign w_hs        = m_wvalid && m_wready;
    assign req_awready = aw_hs ? gnt_oh : '0;
    assign req_wready  = w_hs ? gnt_oh : '0;
    assign req_bvalid  = b_route ? gnt_oh : '0;
    assign req_bresp   = b_route ? m_bresp : 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            err_cnt <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt_idx <= pick_idx;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Either channel may finish first, or both together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WAITB;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                ST_WAITB: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) err_cnt <= sat_inc(err_cnt);
                        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
module tb_hawk_axiwr_arb;

    localparam int NREQ = 3;
    localparam int IDW  = 3;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [NREQ*64-1:0]  req_addr;
    logic [NREQ*512-1:0] req_data;
    logic [NREQ*64-1:0]  req_strb;
    logic [NREQ-1:0]     req_awvalid;
    logic [NREQ-1:0]     req_wvalid;
    logic [NREQ-1:0]     req_awready;
    logic [NREQ-1:0]     req_wready;
    logic [NREQ-1:0]     req_bvalid;
    logic [1:0]          req_bresp;
    logic [63:0]         m_addr;
    logic [511:0]        m_data;
    logic [63:0]         m_strb;
    logic                m_awvalid;
    logic                m_wvalid;
    logic                m_awready;
    logic                m_wready;
    logic                m_bvalid;
    logic [1:0]          m_bresp;
    logic [IDW-1:0]      gnt_idx;
    logic                busy;
    logic [15:0]         err_cnt;

    logic [63:0]  t_addr [NREQ];
    logic [511:0] t_data [NREQ];
    logic [63:0]  t_strb [NREQ];

    int total = 0;
    int bad   = 0;
    int m_rr;
    int m_err;

    hawk_axiwr_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .req_awvalid(req_awvalid), .req_wvalid(req_wvalid),
        .req_awready(req_awready), .req_wready(req_wready),
        .req_bvalid(req_bvalid), .req_bresp(req_bresp),
        .m_addr(m_addr), .m_data(m_data), .m_strb(m_strb),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid),
        .m_awready(m_awready), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp),
        .gnt_idx(gnt_idx), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        req_strb = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*64 +: 64]   = t_addr[i];
            req_data[i*512 +: 512] = t_data[i];
            req_strb[i*64 +: 64]   = t_strb[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr + k) % NREQ;
            if (((mask >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic randomize_payload();
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = {$urandom, $urandom};
            t_strb[i] = {$urandom, $urandom};
            for (int j = 0; j < 16; j++) t_data[i][j*32 +: 32] = $urandom;
        end
    endtask

    task automatic clear_inputs();
        req_awvalid = '0;
        req_wvalid  = '0;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;
        m_bresp     = 2'b00;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_idx, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_mawvalid", m_awvalid, 0);
        chk("rst_mwvalid", m_wvalid, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mstrb", m_strb, 0);
        chk("rst_mdata", 64'(m_data === '0), 1);
        chk("rst_ready", {req_awready, req_wready}, 0);
        chk("rst_bvalid", req_bvalid, 0);
        m_rr  = 0;
        m_err = 0;
    endtask

    // One complete write, entered and left just after a falling edge with the DUT idle.
    task automatic do_txn(input logic [NREQ-1:0] mask, input int awd, input int wd,
                          input int bd, input logic [1:0] br, input int exp_g,
                          input logic [15:0] exp_err, input logic [63:0] fixed_addr,
                          input bit stray);
        logic [NREQ-1:0] oh;
        int last;
        randomize_payload();
        if (fixed_addr != 0) t_addr[exp_g] = fixed_addr;
        oh   = NREQ'(1) << exp_g;
        last = (awd > wd) ? awd : wd;
        req_awvalid = mask;
        req_wvalid  = mask;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_mawvalid", m_awvalid, 0);
        @(negedge clk);
        chk("gnt_idx", gnt_idx, exp_g);
        chk("m_addr", m_addr, t_addr[exp_g]);
        chk("m_strb", m_strb, t_strb[exp_g]);
        chk("m_data", 64'(m_data === t_data[exp_g]), 1);
        for (int c = 0; c <= last; c++) begin
            m_awready = (c >= awd);
            m_wready  = (c >= wd);
            m_bvalid  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            m_bresp   = 2'($urandom_range(0, 3));
            #1;
            chk("xfer_mawvalid", m_awvalid, (c <= awd));
            chk("xfer_mwvalid", m_wvalid, (c <= wd));
            chk("xfer_awready", req_awready, (c == awd) ? oh : '0);
            chk("xfer_wready", req_wready, (c == wd) ? oh : '0);
            chk("xfer_bvalid", req_bvalid, 0);
            chk("xfer_busy", busy, 1);
            @(negedge clk);
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        for (int b = 0; b < bd; b++) begin
            #1;
            chk("waitb_busy", busy, 1);
            chk("waitb_valids", {m_awvalid, m_wvalid}, 0);
            chk("waitb_bvalid", req_bvalid, 0);
            @(negedge clk);
        end
        m_bvalid = 1'b1;
        m_bresp  = br;
        #1;
        chk("bvalid_route", req_bvalid, oh);
        chk("bresp_route", req_bresp, br);
        chk("bvalid_busy", busy, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_bvalid", req_bvalid, 0);
        chk("done_err", err_cnt, exp_err);
        chk("gnt_hold", gnt_idx, exp_g);
        req_awvalid = '0;
        req_wvalid  = '0;
    endtask

    typedef struct {
        bit              rst_first;
        logic [NREQ-1:0] mask;
        int              awd;
        int              wd;
        int              bd;
        logic [1:0]      br;
        int              exp_g;
        logic [15:0]     exp_err;
        logic [63:0]     fixed_addr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 0, 0, 1, 2'b00, 1, 16'd0, 64'hFFF6200040};
        tbl[1]  = '{1'b1, 3'b111, 0, 0, 0, 2'b00, 0, 16'd0, 64'd0};
        tbl[2]  = '{1'b0, 3'b111, 1, 0, 0, 2'b00, 1, 16'd0, 64'd0};
        tbl[3]  = '{1'b0, 3'b111, 0, 1, 2, 2'b00, 2, 16'd0, 64'd0};
        tbl[4]  = '{1'b0, 3'b111, 2, 2, 0, 2'b00, 0, 16'd0, 64'd0};
        tbl[5]  = '{1'b0, 3'b111, 0, 0, 1, 2'b00, 1, 16'd0, 64'd0};
        tbl[6]  = '{1'b0, 3'b111, 1, 1, 0, 2'b00, 2, 16'd0, 64'd0};
        tbl[7]  = '{1'b0, 3'b001, 0, 5, 1, 2'b00, 0, 16'd0, 64'd0};
        tbl[8]  = '{1'b0, 3'b100, 5, 0, 0, 2'b00, 2, 16'd0, 64'd0};
        tbl[9]  = '{1'b0, 3'b110, 0, 0, 0, 2'b10, 1, 16'd1, 64'd0};
        tbl[10] = '{1'b0, 3'b110, 1, 0, 1, 2'b10, 2, 16'd2, 64'd0};
        tbl[11] = '{1'b0, 3'b110, 0, 2, 0, 2'b10, 1, 16'd3, 64'd0};
        tbl[12] = '{1'b0, 3'b101, 2, 2, 0, 2'b01, 2, 16'd4, 64'd0};
        tbl[13] = '{1'b0, 3'b011, 1, 3, 2, 2'b11, 0, 16'd5, 64'd0};
        tbl[14] = '{1'b0, 3'b101, 0, 0, 0, 2'b00, 2, 16'd5, 64'd0};

        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0; t_data[i] = '0; t_strb[i] = '0;
        end
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);

        for (int r = 0; r < 15; r++) begin
            if (tbl[r].rst_first) do_reset();
            do_txn(tbl[r].mask, tbl[r].awd, tbl[r].wd, tbl[r].bd, tbl[r].br,
                   tbl[r].exp_g, tbl[r].exp_err, tbl[r].fixed_addr, 1'b0);
        end

        // Stray B response while idle.
        m_bvalid = 1'b1;
        m_bresp  = 2'b10;
        #1;
        chk("stray_bvalid", req_bvalid, 0);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("stray_err", err_cnt, 5);
        chk("stray_busy", busy, 0);

        // Error counter saturation.
        force dut.err_cnt = 16'hFFFF;
        do_txn(3'b001, 0, 0, 0, 2'b10, 0, 16'hFFFF, 64'd0, 1'b0);
        release dut.err_cnt;
        @(negedge clk);
        #1;
        chk("err_saturate", err_cnt, 16'hFFFF);

        // Reset while waiting for B (pointer is 1 here).
        @(negedge clk);
        randomize_payload();
        req_awvalid = 3'b010;
        req_wvalid  = 3'b010;
        m_awready   = 1'b1;
        m_wready    = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_gnt", gnt_idx, 1);
        @(negedge clk);
        #1;
        chk("mid_waitb_busy", busy, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        clear_inputs();
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bvalid", req_bvalid, 0);
        chk("mid_rst_gnt", gnt_idx, 0);
        chk("mid_rst_err", err_cnt, 0);
        m_bvalid = 1'b1;
        m_bresp  = 2'b10;
        #1;
        chk("mid_late_bvalid", req_bvalid, 0);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("mid_late_err", err_cnt, 0);
        chk("mid_late_busy", busy, 0);
        do_txn(3'b011, 0, 0, 0, 2'b00, 0, 16'd0, 64'd0, 1'b0);
        do_txn(3'b100, 0, 1, 1, 2'b00, 2, 16'd0, 64'd0, 1'b0);

        // Randomized traffic against the reference model.
        m_rr  = 0;
        m_err = 0;
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] mask;
            logic [1:0]      br;
            int              g;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            br   = 2'($urandom_range(0, 3));
            g    = rr_pick(mask, m_rr);
            if (br != 2'b00 && m_err < 16'hFFFF) m_err++;
            if ($urandom_range(0, 3) == 0) begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b11;
                #1;
                chk("rnd_idle_stray", req_bvalid, 0);
                @(negedge clk);
                m_bvalid = 1'b0;
            end
            do_txn(mask, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                   br, g, 16'(m_err), 64'd0, 1'b1);
            m_rr = (g + 1) % NREQ;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
